// File: rtl/tproc_isa_pkg.sv
// -----------------------------------------------------------------------------
// tproc_isa_pkg
//   Shared instruction-set constants for the accelerator control path:
//   opcode values, the position and width of the opcode field, and the
//   execution-unit indices. Also provides a helper that maps a unit index to
//   the opcode that addresses it.
// -----------------------------------------------------------------------------
package tproc_isa_pkg;

  // Opcode field occupies the top OPC_W bits of the instruction word.
  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OPC_NOP   = 4'd0;
  localparam logic [OPC_W-1:0] OPC_LOAD  = 4'd1;
  localparam logic [OPC_W-1:0] OPC_CONV  = 4'd2;
  localparam logic [OPC_W-1:0] OPC_STORE = 4'd3;

  // Execution-unit indices (bit positions in unit_start / unit_done).
  localparam int UNIT_LOAD  = 0;
  localparam int UNIT_CONV  = 1;
  localparam int UNIT_STORE = 2;

  // Unit opcodes are contiguous starting at OPC_LOAD, in unit-index order.
  function automatic logic [OPC_W-1:0] unit_opcode(input int unsigned idx);
    return OPC_LOAD + OPC_W'(idx);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
//   Purely combinational opcode decoder. Kept as its own block so the same
//   decode can be reused by trace/debug logic.
// Ports
//   opcode     in   OPC_W     opcode field of an instruction
//   unit_sel   out  N_UNITS   one-hot select of the addressed unit (0 if none)
//   is_nop     out  1         opcode is NOP
//   is_illegal out  1         opcode is neither NOP nor a unit opcode
// -----------------------------------------------------------------------------
module instr_decode
  import tproc_isa_pkg::*;
#(
  parameter int N_UNITS = 3
) (
  input  logic [OPC_W-1:0]   opcode,
  output logic [N_UNITS-1:0] unit_sel,
  output logic               is_nop,
  output logic               is_illegal
);

  for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_sel
    assign unit_sel[gi] = (opcode == unit_opcode(gi));
  end

  assign is_nop     = (opcode == OPC_NOP);
  assign is_illegal = !is_nop && !(|unit_sel);

endmodule

// File: rtl/instr_dispatch.sv
// -----------------------------------------------------------------------------
// instr_dispatch
//   Sequences one decoded instruction at a time onto the execution units
//   (load, conv, store). Starts the addressed unit with the instruction
//   payload, waits for its done (guarded by a watchdog) and returns a
//   one-cycle retire pulse to the fetch FSM. Illegal opcodes and hung units
//   raise sticky error flags but always retire, so fetch never deadlocks.
// Ports
//   clk                in   1          clock, rising edge
//   rst                in   1          asynchronous active-high reset
//   instruction_enable in   1          one-cycle strobe, ctr valid
//   ctr                in   INSTR_W    instruction word
//   busy               out  1          high whenever not IDLE
//   unit_start         out  N_UNITS    one-hot one-cycle start pulse
//   unit_param         out  INSTR_W-4  payload of the current instruction
//   unit_done          in   N_UNITS    per-unit completion
//   instr_exe_state    out  1          one-cycle retire pulse
//   err_clr            in   1          clears sticky error flags
//   err_illegal        out  1          sticky: illegal opcode retired
//   err_timeout        out  1          sticky: unit watchdog expired
//   exec_cnt           out  32         retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module instr_dispatch
  import tproc_isa_pkg::*;
#(
  parameter int INSTR_W   = 64,
  parameter int N_UNITS   = 3,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instruction_enable,
  input  logic [INSTR_W-1:0]   ctr,
  output logic                 busy,
  output logic [N_UNITS-1:0]   unit_start,
  output logic [INSTR_W-5:0]   unit_param,
  input  logic [N_UNITS-1:0]   unit_done,
  output logic                 instr_exe_state,
  input  logic                 err_clr,
  output logic                 err_illegal,
  output logic                 err_timeout,
  output logic [31:0]          exec_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WD_MAX = {TIMEOUT_W{1'b1}};

  state_t               state;
  logic [OPC_W-1:0]     opcode_reg;
  logic [TIMEOUT_W-1:0] watchdog;

  // Decoder input: in IDLE the incoming word is decoded so the unit can be
  // started the very next cycle; otherwise the latched opcode is decoded,
  // which gives the unit select used to qualify done while waiting.
  logic [OPC_W-1:0]   dec_opcode;
  logic [N_UNITS-1:0] dec_sel;
  logic               dec_nop;
  logic               dec_illegal;

  assign dec_opcode = (state == ST_IDLE) ? ctr[INSTR_W-1 -: OPC_W] : opcode_reg;

  instr_decode #(
    .N_UNITS (N_UNITS)
  ) u_decode (
    .opcode     (dec_opcode),
    .unit_sel   (dec_sel),
    .is_nop     (dec_nop),
    .is_illegal (dec_illegal)
  );

  logic accept;
  logic done_hit;
  logic set_illegal;
  logic set_timeout;

  assign accept      = (state == ST_IDLE) && instruction_enable;
  assign set_illegal = accept && dec_illegal;
  // Only the addressed unit's done counts; done beats an expiring watchdog.
  assign done_hit    = (state == ST_WAIT) && (|(unit_done & dec_sel));
  assign set_timeout = (state == ST_WAIT) && !done_hit && (watchdog == WD_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      opcode_reg      <= '0;
      watchdog        <= '0;
      busy            <= 1'b0;
      unit_start      <= '0;
      unit_param      <= '0;
      instr_exe_state <= 1'b0;
      err_illegal     <= 1'b0;
      err_timeout     <= 1'b0;
      exec_cnt        <= '0;
    end else begin
      // Pulse outputs default low so they can never stretch to two cycles.
      unit_start      <= '0;
      instr_exe_state <= 1'b0;

      // Sticky flags: a set in the same cycle as a clear wins.
      err_illegal <= set_illegal | (err_illegal & ~err_clr);
      err_timeout <= set_timeout | (err_timeout & ~err_clr);

      case (state)
        ST_IDLE: begin
          if (instruction_enable) begin
            opcode_reg <= ctr[INSTR_W-1 -: OPC_W];
            unit_param <= ctr[INSTR_W-5:0];
            busy       <= 1'b1;
            if (dec_nop || dec_illegal) begin
              // Nothing to execute: retire straight away.
              state           <= ST_DONE;
              instr_exe_state <= 1'b1;
              exec_cnt        <= exec_cnt + 32'd1;
            end else begin
              state      <= ST_ISSUE;
              unit_start <= dec_sel;
            end
          end
        end

        ST_ISSUE: begin
          watchdog <= '0;
          state    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (done_hit || set_timeout) begin
            state           <= ST_DONE;
            instr_exe_state <= 1'b1;
            exec_cnt        <= exec_cnt + 32'd1;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_dispatch.sv
// -----------------------------------------------------------------------------
// tb_instr_dispatch
//   Directed self-checking bench for instr_dispatch (TIMEOUT_W = 4).
// -----------------------------------------------------------------------------
module tb_instr_dispatch;

  logic        clk;
  logic        rst;
  logic        instruction_enable;
  logic [63:0] ctr;
  logic        busy;
  logic [2:0]  unit_start;
  logic [59:0] unit_param;
  logic [2:0]  unit_done;
  logic        instr_exe_state;
  logic        err_clr;
  logic        err_illegal;
  logic        err_timeout;
  logic [31:0] exec_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int start_seen [3];
  int exe_seen;
  int exp_cnt;
  int s0, s1, s2, e0;

  instr_dispatch #(
    .INSTR_W   (64),
    .N_UNITS   (3),
    .TIMEOUT_W (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .instruction_enable (instruction_enable),
    .ctr                (ctr),
    .busy               (busy),
    .unit_start         (unit_start),
    .unit_param         (unit_param),
    .unit_done          (unit_done),
    .instr_exe_state    (instr_exe_state),
    .err_clr            (err_clr),
    .err_illegal        (err_illegal),
    .err_timeout        (err_timeout),
    .exec_cnt           (exec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tally, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++)
      if (unit_start[i]) start_seen[i] = start_seen[i] + 1;
    if (instr_exe_state) exe_seen = exe_seen + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s got %0h", tag, got);
    end else begin
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one instruction for one cycle; returns 1 ns into the cycle after
  // the sampling edge.
  task automatic strobe(input logic [3:0] op, input logic [59:0] payload);
    @(posedge clk); #1;
    instruction_enable = 1'b1;
    ctr = {op, payload};
    @(posedge clk); #1;
    instruction_enable = 1'b0;
    ctr = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one unit's done for exactly one cycle; returns in the following cycle.
  task automatic pulse_done(input logic [2:0] d);
    unit_done = d;
    tick(1);
    unit_done = '0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) start_seen[i] = 0;
    exe_seen = 0;
    exp_cnt  = 0;
    rst = 1'b1;
    instruction_enable = 1'b0;
    ctr = '0;
    unit_done = '0;
    err_clr = 1'b0;
    #1;
    check("rst_busy",   busy, 0);
    check("rst_start",  unit_start, 0);
    check("rst_param",  unit_param, 0);
    check("rst_cnt",    exec_cnt, 0);
    check("rst_errs",   {err_illegal, err_timeout, instr_exe_state}, 0);
    tick(2);
    rst = 1'b0;

    // 1: CONV with payload 0x123, done 5 cycles after start.
    strobe(4'h2, 60'h123);
    check("t1_start", unit_start, 3'b010);
    check("t1_param", unit_param, 60'h123);
    check("t1_busy",  busy, 1);
    tick(4);
    check("t1_nostart_wait", unit_start, 0);
    pulse_done(3'b010);
    exp_cnt++;
    check("t1_exe", instr_exe_state, 1);
    check("t1_cnt", exec_cnt, exp_cnt);
    check("t1_param_done", unit_param, 60'h123);
    tick(1);
    check("t1_exe_off", instr_exe_state, 0);
    check("t1_idle", busy, 0);

    // 2: LOAD, wrong unit's done ignored, then correct done retires.
    strobe(4'h1, 60'hABC);
    check("t2_start", unit_start, 3'b001);
    tick(2);
    pulse_done(3'b100);
    tick(2);
    check("t2_still_busy", busy, 1);
    check("t2_no_exe", instr_exe_state, 0);
    pulse_done(3'b001);
    exp_cnt++;
    check("t2_exe", instr_exe_state, 1);
    check("t2_cnt", exec_cnt, exp_cnt);
    check("t2_errs", {err_illegal, err_timeout}, 0);

    // 3: NOP then illegal opcode 0xF, each retiring one cycle after strobe.
    s0 = start_seen[0]; s1 = start_seen[1]; s2 = start_seen[2];
    strobe(4'h0, 60'h0);
    exp_cnt++;
    check("t3_nop_exe", instr_exe_state, 1);
    check("t3_nop_cnt", exec_cnt, exp_cnt);
    check("t3_nop_noerr", err_illegal, 0);
    strobe(4'hF, 60'h5);
    exp_cnt++;
    check("t3_ill_exe", instr_exe_state, 1);
    check("t3_ill_flag", err_illegal, 1);
    check("t3_ill_cnt", exec_cnt, exp_cnt);
    tick(3);
    check("t3_no_starts", start_seen[0] + start_seen[1] + start_seen[2], s0 + s1 + s2);
    check("t3_sticky", err_illegal, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t3_clr", err_illegal, 0);

    // 4: STORE with no done: watchdog runs 16 WAIT cycles (values 0..15).
    strobe(4'h3, 60'h77);
    check("t4_start", unit_start, 3'b100);
    tick(16);
    check("t4_pre_to", err_timeout, 0);
    check("t4_pre_busy", busy, 1);
    tick(1);
    exp_cnt++;
    check("t4_to_flag", err_timeout, 1);
    check("t4_to_exe", instr_exe_state, 1);
    check("t4_to_cnt", exec_cnt, exp_cnt);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t4_clr", err_timeout, 0);
    // Done arrives in the last WAIT cycle, same cycle the watchdog expires.
    strobe(4'h3, 60'h78);
    tick(16);
    pulse_done(3'b100);
    exp_cnt++;
    check("t4_late_exe", instr_exe_state, 1);
    check("t4_late_noerr", err_timeout, 0);

    // 5: strobe while busy is ignored.
    tick(1);
    s0 = start_seen[0]; s1 = start_seen[1];
    strobe(4'h1, 60'h55);
    tick(1);
    instruction_enable = 1'b1;
    ctr = {4'h2, 60'h99};
    tick(1);
    instruction_enable = 1'b0;
    ctr = '0;
    check("t5_param_held", unit_param, 60'h55);
    check("t5_busy", busy, 1);
    tick(1);
    pulse_done(3'b001);
    exp_cnt++;
    check("t5_exe", instr_exe_state, 1);
    tick(2);
    check("t5_load_starts", start_seen[0] - s0, 1);
    check("t5_conv_starts", start_seen[1] - s1, 0);
    check("t5_param_after", unit_param, 60'h55);
    check("t5_cnt", exec_cnt, exp_cnt);

    // 6: asynchronous reset while waiting.
    strobe(4'h1, 60'h42);
    tick(1);
    e0 = exe_seen;
    #2;
    rst = 1'b1;
    #1;
    check("t6_busy", busy, 0);
    check("t6_cnt", exec_cnt, 0);
    check("t6_param", unit_param, 0);
    tick(2);
    rst = 1'b0;
    check("t6_no_exe", exe_seen, e0);
    strobe(4'h1, 60'h1);
    check("t6_start", unit_start, 3'b001);
    tick(2);
    pulse_done(3'b001);
    check("t6_exe", instr_exe_state, 1);
    check("t6_cnt1", exec_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
